inst_queue: RTL and testbench

Instruction fetch queue between the fetch stage and decode. It buffers fetched instruction/PC pairs in a small circular FIFO, decoupling fetch from decode-side stalls. It raises a stall request to fetch when it cannot accept, and it is emptied by a pipeline flush. Decode sees a first-word-fall-through head entry with a valid/ready handshake, and a NOP whenever the queue is empty.

---
 rtl/inst_queue_pkg.sv | 23 ++
 rtl/inst_queue_fifo_ptr.sv | 25 ++
 rtl/inst_queue.sv | 99 +++++++++
 tb/tb_inst_queue.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
// Bus widths and the NOP encoding mirror the global pipeline defines.
package inst_queue_pkg;

    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [31:0] NopInst     = 32'h0000_0013;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } count_op_e;

    // A simultaneous push and pop leaves the occupancy untouched.
    function automatic count_op_e count_op(input logic push, input logic pop);
        if (push && !pop) return CNT_INC;
        if (pop && !push) return CNT_DEC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/inst_queue_fifo_ptr.sv
// Circular FIFO pointer (fifo_ptr): advances by one and wraps modulo DEPTH.
// A synchronous clear lets a pipeline flush rewind it at the next edge.
module inst_queue_fifo_ptr #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [PW-1:0] ptr
);

    // Explicit wrap keeps the pointer correct even if PW is ever widened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Instruction fetch queue: circular FIFO of instruction/PC pairs between fetch and decode.
// Head is first-word-fall-through; an empty queue presents a NOP at PC 0.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int             DEPTH = 4,
    parameter int             AW    = InstAddrBus,
    parameter int             DW    = InstBus,
    parameter logic [DW-1:0]  NOP   = DW'(NopInst)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       I_valid,
    input  logic [DW-1:0]              I_inst,
    input  logic [AW-1:0]              I_inst_addr,
    output logic                       O_stallreq,
    input  logic                       I_flush,
    output logic                       O_valid,
    output logic [DW-1:0]              O_inst,
    output logic [AW-1:0]              O_inst_addr,
    input  logic                       I_ready,
    output logic [$clog2(DEPTH+1)-1:0] O_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_inst [DEPTH];
    logic [AW-1:0] mem_addr [DEPTH];

    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count;

    logic empty;
    logic full;
    logic pop;
    logic push;

    // Flush masks both handshakes so nothing moves in the cycle it is raised.
    always_comb begin
        empty      = (count == '0);
        full       = (count == CW'(DEPTH));
        O_valid    = !empty && !I_flush;
        pop        = O_valid && I_ready;
        push       = I_valid && !I_flush && (!full || pop);
        O_stallreq = I_valid && !I_flush && full && !pop;
    end

    always_comb begin
        O_inst      = NOP;
        O_inst_addr = AW'(ZeroWord);
        if (!empty) begin
            O_inst      = mem_inst[rptr];
            O_inst_addr = mem_addr[rptr];
        end
    end

    inst_queue_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rptr (
        .clk     (clk),
        .rst     (rst),
        .clear   (I_flush),
        .advance (pop),
        .ptr     (rptr)
    );

    inst_queue_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wptr (
        .clk     (clk),
        .rst     (rst),
        .clear   (I_flush),
        .advance (push),
        .ptr     (wptr)
    );

    // Storage is deliberately left unreset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wptr] <= I_inst;
            mem_addr[wptr] <= I_inst_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (I_flush) begin
            count <= '0;
        end else begin
            unique case (count_op(push, pop))
                CNT_INC:  count <= count + CW'(1);
                CNT_DEC:  count <= count - CW'(1);
                default:  count <= count;
            endcase
        end
    end

    assign O_count = count;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a queue scoreboard tracks accepted pushes
// and is compared against the head, occupancy and stall request every cycle.
module tb_inst_queue;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        I_valid;
    logic [31:0] I_inst;
    logic [31:0] I_inst_addr;
    logic        O_stallreq;
    logic        I_flush;
    logic        O_valid;
    logic [31:0] O_inst;
    logic [31:0] O_inst_addr;
    logic        I_ready;
    logic [2:0]  O_count;

    entry_t sb[$];
    int     tests = 0;
    int     fails = 0;

    inst_queue dut (
        .clk         (clk),
        .rst         (rst),
        .I_valid     (I_valid),
        .I_inst      (I_inst),
        .I_inst_addr (I_inst_addr),
        .O_stallreq  (O_stallreq),
        .I_flush     (I_flush),
        .O_valid     (O_valid),
        .O_inst      (O_inst),
        .O_inst_addr (O_inst_addr),
        .I_ready     (I_ready),
        .O_count     (O_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle, checks the combinational view against the scoreboard,
    // then advances the model and the clock together.
    task automatic apply_stimulus(input logic v, input logic [31:0] addr,
                                  input logic rdy, input logic fl);
        logic   exp_valid;
        logic   exp_pop;
        logic   exp_push;
        logic   exp_stall;
        entry_t e;
        I_valid     = v;
        I_inst_addr = addr;
        I_inst      = v ? $urandom : 32'h0;
        I_ready     = rdy;
        I_flush     = fl;
        e.inst      = I_inst;
        e.addr      = addr;
        #1;
        exp_valid = (sb.size() != 0) && !fl;
        exp_pop   = exp_valid && rdy;
        exp_stall = v && !fl && (sb.size() == 4) && !exp_pop;
        exp_push  = v && !fl && ((sb.size() < 4) || exp_pop);
        check_output("valid", 32'(O_valid), 32'(exp_valid));
        check_output("count", 32'(O_count), 32'(sb.size()));
        check_output("stallreq", 32'(O_stallreq), 32'(exp_stall));
        if (exp_valid) begin
            check_output("head_inst", O_inst, sb[0].inst);
            check_output("head_addr", O_inst_addr, sb[0].addr);
        end else if (sb.size() == 0) begin
            check_output("empty_inst", O_inst, NOP_WORD);
            check_output("empty_addr", O_inst_addr, 32'h0);
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (exp_pop)  void'(sb.pop_front());
            if (exp_push) sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        I_valid     = 1'b0;
        I_inst      = 32'h0;
        I_inst_addr = 32'h0;
        I_ready     = 1'b0;
        I_flush     = 1'b0;

        #2;
        check_output("rst_valid", 32'(O_valid), 32'h0);
        check_output("rst_inst", O_inst, NOP_WORD);
        check_output("rst_addr", O_inst_addr, 32'h0);
        check_output("rst_count", 32'(O_count), 32'h0);
        check_output("rst_stall", 32'(O_stallreq), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);

        // Fill without drain, then a stalled fifth push.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0, 1'b0);
        check_output("fill_count", 32'(O_count), 32'd4);
        I_valid     = 1'b1;
        I_inst_addr = 32'h8000_0010;
        #1;
        check_output("full_stall", 32'(O_stallreq), 32'h1);
        apply_stimulus(1'b1, 32'h8000_0010, 1'b0, 1'b0);
        check_output("full_count", 32'(O_count), 32'd4);
        check_output("full_head", O_inst_addr, 32'h8000_0000);

        // Full with simultaneous pop and push.
        I_ready = 1'b1;
        #1;
        check_output("popush_stall", 32'(O_stallreq), 32'h0);
        apply_stimulus(1'b1, 32'h8000_0010, 1'b1, 1'b0);
        check_output("popush_head", O_inst_addr, 32'h8000_0004);
        check_output("popush_count", 32'(O_count), 32'd4);

        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        check_output("drain_count", 32'(O_count), 32'd0);

        // Streaming: twelve PCs through four slots wraps the pointers three times.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b1, 1'b0);
            check_output("stream_addr", O_inst_addr, 32'h8000_0000 + 32'(4 * i));
        end
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        check_output("stream_count", 32'(O_count), 32'd0);

        // Flush with a push pending.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h8000_0020 + 32'(4 * i), 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h8000_0100, 1'b0, 1'b1);
        check_output("flush_count", 32'(O_count), 32'd0);
        check_output("flush_valid", 32'(O_valid), 32'h0);
        apply_stimulus(1'b1, 32'h8000_0200, 1'b0, 1'b0);
        check_output("post_flush_head", O_inst_addr, 32'h8000_0200);
        check_output("post_flush_valid", 32'(O_valid), 32'h1);

        // Asynchronous reset between edges with two entries queued.
        apply_stimulus(1'b1, 32'h8000_0204, 1'b0, 1'b0);
        I_valid = 1'b0;
        check_output("pre_arst_count", 32'(O_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_output("arst_valid", 32'(O_valid), 32'h0);
        check_output("arst_count", 32'(O_count), 32'h0);
        check_output("arst_stall", 32'(O_stallreq), 32'h0);
        check_output("arst_inst", O_inst, NOP_WORD);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h8000_0300 + 32'(4 * i), 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
